// File: rtl/rv_mem_pkg.sv
// Shared encodings and helpers for the memory-stage load/store unit.
package rv_mem_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StSplit,
    StResp
  } state_e;

  // Bytes are always aligned; illegal sizes are handled separately.
  function automatic logic is_misaligned(logic [1:0] addr_lsb, logic [1:0] size);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_HALF: mis = addr_lsb[0];
      SIZE_WORD: mis = (addr_lsb != 2'b00);
      default:   mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of assembled load data to 32 bits.
module load_extend
  import rv_mem_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] ext_o
);

  always_comb begin
    ext_o = data_i;
    case (size_i)
      SIZE_BYTE: ext_o = unsigned_i ? {24'h0, data_i[7:0]} : {{24{data_i[7]}}, data_i[7:0]};
      SIZE_HALF: ext_o = unsigned_i ? {16'h0, data_i[15:0]} : {{16{data_i[15]}}, data_i[15:0]};
      default:   ext_o = data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one request per transaction, misaligned accesses
// optionally split into aligned byte accesses, response on a valid/ready channel.
module load_store_unit
  import rv_mem_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic        req_we_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] mem_a_o,
  output logic [31:0] mem_wd_o,
  output logic [1:0]  mem_data_size_o,
  output logic        mem_data_unsigned_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_rd_i
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic        we_q, we_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] buf_merged;
  logic [31:0] split_ext;
  logic [1:0]  k_last;

  // Load buffer with the byte arriving this SPLIT cycle already merged in.
  always_comb begin
    buf_merged = buf_q;
    buf_merged[{k_q, 3'b000} +: 8] = mem_rd_i[7:0];
  end

  assign k_last = (size_q == SIZE_HALF) ? 2'd1 : 2'd3;

  load_extend u_load_extend (
    .data_i     (buf_merged),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .ext_o      (split_ext)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    we_d       = we_q;
    k_d        = k_q;
    buf_d      = buf_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d     = req_addr_i;
          wdata_d    = req_wdata_i;
          size_d     = req_size_i;
          unsigned_d = req_unsigned_i;
          we_d       = req_we_i;
          k_d        = 2'd0;
          buf_d      = 32'h0;
          rdata_d    = 32'h0;
          err_d      = 1'b0;
          if (req_size_i == SIZE_ILLEGAL) begin
            state_d = StResp;
            err_d   = 1'b1;
          end else if (is_misaligned(req_addr_i[1:0], req_size_i)) begin
            if (ALLOW_MISALIGNED) begin
              state_d = StSplit;
            end else begin
              state_d = StResp;
              err_d   = 1'b1;
            end
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        state_d = StResp;
        rdata_d = we_q ? 32'h0 : mem_rd_i;
      end
      StSplit: begin
        buf_d = buf_merged;
        k_d   = k_q + 2'd1;
        if (k_q == k_last) begin
          state_d = StResp;
          rdata_d = we_q ? 32'h0 : split_ext;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      size_q     <= SIZE_BYTE;
      unsigned_q <= 1'b1;
      we_q       <= 1'b0;
      k_q        <= 2'd0;
      buf_q      <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      we_q       <= we_d;
      k_q        <= k_d;
      buf_q      <= buf_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Memory port is idle (and write-disabled) outside ACCESS/SPLIT, including during reset.
  always_comb begin
    mem_a_o             = 32'h0;
    mem_wd_o            = 32'h0;
    mem_data_size_o     = SIZE_BYTE;
    mem_data_unsigned_o = 1'b1;
    mem_we_o            = 1'b0;
    unique case (state_q)
      StAccess: begin
        mem_a_o             = addr_q;
        mem_wd_o            = wdata_q;
        mem_data_size_o     = size_q;
        mem_data_unsigned_o = unsigned_q;
        mem_we_o            = we_q;
      end
      StSplit: begin
        mem_a_o  = addr_q + {30'h0, k_q};
        mem_wd_o = {24'h0, wdata_q[{k_q, 3'b000} +: 8]};
        mem_we_o = we_q;
      end
      default: ;
    endcase
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule
